pixel_coord_generator: RTL and testbench
========================================

// Module: pixel_coord_generator
// PURPOSE
//  Frame-level pixel sequencer feeding ray_generator_folded. On a frame start it
//  walks every pixel in raster order (h fastest). For each pixel it presents the
//  integer coords, normalised fp screen coords and the frame's camera forward vector.
//  Transfers use a valid/ready handshake against the ray generator's ready_out.
//  Normalised coords are px = (2h - W)/H and py = (2v - H)/H, built incrementally (no multipliers).
// PARAMETERS
//  DISPLAY_WIDTH   `DISPLAY_WIDTH   pixels per row (W)
//  DISPLAY_HEIGHT  `DISPLAY_HEIGHT  rows per frame (H)
//  H_BITS          `H_BITS          width of hcount
//  V_BITS          `V_BITS          width of vcount
// PORTS
//  clk_in          in   1       system clock
//  rst_n_in        in   1       asynchronous, active-low reset
//  start_in        in   1       begin a frame; sampled only in IDLE
//  cam_forward_in  in   vec3    camera forward; latched on accepted start_in
//  ready_in        in   1       downstream ready (ray generator ready_out)
//  valid_out       out  1       pixel beat valid
//  hcount_out      out  H_BITS  pixel column
//  vcount_out      out  V_BITS  pixel row
//  hcount_fp_out   out  fp      px for this pixel
//  vcount_fp_out   out  fp      py for this pixel
//  cam_forward_out out  vec3    latched camera forward, constant for the frame
//  busy_out        out  1       high from accepted start until frame_done_out
//  frame_done_out  out  1       one-cycle pulse after the last pixel's handshake
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE.
//   valid_out, busy_out and frame_done_out are 0.
//   hcount/vcount are 0, hcount_fp and vcount_fp are 0, cam_forward_out is 0.
//  States: IDLE -> LOAD -> EMIT -> DONE -> IDLE.
//  IDLE: on start_in=1, latch cam_forward_in, set busy_out=1 and go to LOAD.
//  LOAD: h=0, v=0, px=FP_PX_START, py=FP_PY_START. Go to EMIT.
//   valid_out rises 2 cycles after the start_in edge.
//  EMIT: valid_out=1. A transfer occurs on a cycle with valid_out && ready_in.
//   With no transfer, all outputs hold stable (no change under backpressure).
//   On transfer with h<W-1: h++ and px+=FP_PIX_STEP. Stay in EMIT; next beat follows
//   the next cycle with no bubble.
//   On transfer with h==W-1 and v<H-1: h=0, px=FP_PX_START (reloaded, not accumulated),
//   v++ and py+=FP_PIX_STEP. Stay in EMIT.
//   On transfer with h==W-1 and v==H-1: valid_out=0 and go to DONE.
//  DONE: frame_done_out=1 for exactly one cycle, busy_out=0, go to IDLE.
//   The next start_in is accepted from IDLE on the following cycle.
//  start_in outside IDLE is ignored. cam_forward_in changes mid-frame are ignored.
//  Arithmetic: fp adds wrap per fp_add. px is exact at every row start. py drift is
//   at most (H-1) LSBs of step rounding; vcount_fp at the final row is within H LSB of
//   (H-2)/H.
//  ready_in while valid_out=0 has no effect.
//  Async reset mid-frame aborts immediately. No frame_done_out pulse is issued.
// STRUCTURE
//  Shared package/header (vector_arith.svh): fp, vec3, fp_add.
//  Add constants FP_PIX_STEP = 2/H, FP_PX_START = -W/H, FP_PY_START = -1.0,
//   each as fp with NUM_FRAC_DIGITS fraction bits.
//  State enum is local to this module.
//  No sub-module: two counters plus two fp accumulators and a 4-state FSM.
// TESTING (W=4, H=2, NUM_FRAC_DIGITS=16; step=1.0, px0=-2.0, py0=-1.0)
//  Reset then start_in pulse, ready_in=1: beats (h,v,px,py) are
//   (0,0,-2,-1) (1,0,-1,-1) (2,0,0,-1) (3,0,1,-1) (0,1,-2,0) .. (3,1,1,0).
//   This is 8 beats on consecutive cycles. frame_done_out pulses once, one cycle after beat 8.
//  Backpressure: hold ready_in=0 for 5 cycles at beat 3.
//   Outputs stay frozen at (2,0,0,-1). Exactly 8 beats are total.
//  ready_in toggling every cycle: 8 beats in 16 cycles, no duplicate or skipped (h,v).
//  start_in pulsed again mid-frame with a different cam_forward_in.
//   The start is ignored; cam_forward_out is unchanged; busy_out stays 1.
//  rst_n_in asserted at beat 5: valid_out, busy_out and counters go to 0 asynchronously.
//   No frame_done_out. A new start then gives a full 8-beat frame starting at (0,0).
//  Back-to-back frames: start_in on the cycle after frame_done_out.
//   The second frame is identical and uses its newly latched cam_forward_in.

Source files
------------

// File: rtl/pixel_coord_generator_pkg.sv
// Shared fixed-point types and helpers for the pixel sequencer.
//   fp        signed fixed point, NUM_FRAC_DIGITS fraction bits
//   vec3      packed {x, y, z} of fp
//   fp_add    wrapping fp addition
//   fp_ratio  elaboration-time num/den as fp (truncates toward zero)
package pixel_coord_generator_pkg;

   localparam int NUM_FRAC_DIGITS = 16;
   localparam int FP_WIDTH        = 32;

   typedef logic signed [FP_WIDTH-1:0] fp;

   typedef struct packed {
      fp x;
      fp y;
      fp z;
   } vec3;

   // Two's-complement add; overflow wraps silently.
   function automatic fp fp_add(input fp a, input fp b);
      return a + b;
   endfunction

   function automatic fp fp_ratio(input int num, input int den);
      longint scaled;
      scaled = longint'(num) * (longint'(1) <<< NUM_FRAC_DIGITS);
      return fp'(scaled / longint'(den));
   endfunction

endpackage

// File: rtl/pixel_coord_generator.sv
// Frame-level pixel sequencer. On an accepted start it walks every pixel in
// raster order (h fastest) and presents integer coords, normalised screen
// coords px = (2h - W)/H, py = (2v - H)/H and the latched camera forward over
// a valid/ready handshake. The normalised coords are accumulated, not multiplied.
//
// Ports
//   clk_in, rst_n_in   clock, async active-low reset
//   start_in           begin a frame (only looked at in IDLE)
//   cam_forward_in     camera forward, captured with the accepted start
//   ready_in           downstream ready
//   valid_out          pixel beat valid
//   hcount_out/vcount_out        integer column/row
//   hcount_fp_out/vcount_fp_out  px/py for the current pixel
//   cam_forward_out    camera forward for the whole frame
//   busy_out           accepted start until frame_done_out
//   frame_done_out     one-cycle pulse after the final handshake
//
// state | meaning
// IDLE  | waiting for start_in
// LOAD  | counters and accumulators set to the first pixel
// EMIT  | presenting beats; advances on valid && ready
// DONE  | frame_done pulse, back to IDLE
module pixel_coord_generator
   import pixel_coord_generator_pkg::*;
#(
   parameter int DISPLAY_WIDTH  = 640,
   parameter int DISPLAY_HEIGHT = 480,
   parameter int H_BITS         = 10,
   parameter int V_BITS         = 9
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              start_in,
   input  vec3               cam_forward_in,
   input  logic              ready_in,
   output logic              valid_out,
   output logic [H_BITS-1:0] hcount_out,
   output logic [V_BITS-1:0] vcount_out,
   output fp                 hcount_fp_out,
   output fp                 vcount_fp_out,
   output vec3               cam_forward_out,
   output logic              busy_out,
   output logic              frame_done_out
);

   localparam fp FP_PIX_STEP = fp_ratio(2, DISPLAY_HEIGHT);
   localparam fp FP_PX_START = fp_ratio(-DISPLAY_WIDTH, DISPLAY_HEIGHT);
   localparam fp FP_PY_START = fp_ratio(-1, 1);

   localparam logic [H_BITS-1:0] H_LAST = H_BITS'(DISPLAY_WIDTH - 1);
   localparam logic [V_BITS-1:0] V_LAST = V_BITS'(DISPLAY_HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EMIT,
      ST_DONE
   } state_t;

   state_t            state_q;
   logic              valid_q;
   logic              busy_q;
   logic              done_q;
   logic [H_BITS-1:0] h_q;
   logic [V_BITS-1:0] v_q;
   fp                 px_q;
   fp                 py_q;
   vec3               cam_q;

   logic xfer;
   assign xfer = valid_q && ready_in;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         h_q     <= '0;
         v_q     <= '0;
         px_q    <= '0;
         py_q    <= '0;
         cam_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_in) begin
                  cam_q   <= cam_forward_in;
                  busy_q  <= 1'b1;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               h_q     <= '0;
               v_q     <= '0;
               px_q    <= FP_PX_START;
               py_q    <= FP_PY_START;
               valid_q <= 1'b1;
               state_q <= ST_EMIT;
            end
            ST_EMIT: begin
               if (xfer) begin
                  if (h_q != H_LAST) begin
                     h_q  <= h_q + 1'b1;
                     px_q <= fp_add(px_q, FP_PIX_STEP);
                  end else if (v_q != V_LAST) begin
                     // Reload px at each row start so row error never accumulates.
                     h_q  <= '0;
                     px_q <= FP_PX_START;
                     v_q  <= v_q + 1'b1;
                     py_q <= fp_add(py_q, FP_PIX_STEP);
                  end else begin
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign valid_out       = valid_q;
   assign busy_out        = busy_q;
   assign frame_done_out  = done_q;
   assign hcount_out      = h_q;
   assign vcount_out      = v_q;
   assign hcount_fp_out   = px_q;
   assign vcount_fp_out   = py_q;
   assign cam_forward_out = cam_q;

endmodule

// File: tb/tb_pixel_coord_generator.sv
module tb_pixel_coord_generator;
   import pixel_coord_generator_pkg::*;

   localparam int W  = 4;
   localparam int H  = 2;
   localparam int HB = 2;
   localparam int VB = 1;
   localparam int ONE = 65536;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          ready = 1'b0;
   vec3           cam_in = '0;
   logic          valid_out;
   logic [HB-1:0] hcount_out;
   logic [VB-1:0] vcount_out;
   fp             hcount_fp_out;
   fp             vcount_fp_out;
   vec3           cam_forward_out;
   logic          busy_out;
   logic          frame_done_out;

   pixel_coord_generator #(
      .DISPLAY_WIDTH (W),
      .DISPLAY_HEIGHT(H),
      .H_BITS        (HB),
      .V_BITS        (VB)
   ) dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .start_in       (start),
      .cam_forward_in (cam_in),
      .ready_in       (ready),
      .valid_out      (valid_out),
      .hcount_out     (hcount_out),
      .vcount_out     (vcount_out),
      .hcount_fp_out  (hcount_fp_out),
      .vcount_fp_out  (vcount_fp_out),
      .cam_forward_out(cam_forward_out),
      .busy_out       (busy_out),
      .frame_done_out (frame_done_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [HB-1:0] h;
      logic [VB-1:0] v;
      fp             px;
      fp             py;
      vec3           cam;
   } beat_t;

   beat_t sb[$];
   int    checks = 0;
   int    errors = 0;
   int    beat_cnt = 0;
   int    done_cnt = 0;
   bit    mon_en = 1'b0;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic vec3 mkcam(input int a, input int b, input int c);
      vec3 r;
      r.x = fp'(a * ONE);
      r.y = fp'(b * ONE);
      r.z = fp'(c * ONE);
      return r;
   endfunction

   // Reference: px = (2h - W)/H, py = (2v - H)/H computed directly.
   task automatic push_frame(input vec3 c);
      beat_t b;
      for (int v = 0; v < H; v++) begin
         for (int h = 0; h < W; h++) begin
            b.h   = HB'(h);
            b.v   = VB'(v);
            b.px  = fp'(((2 * h - W) * ONE) / H);
            b.py  = fp'(((2 * v - H) * ONE) / H);
            b.cam = c;
            sb.push_back(b);
         end
      end
   endtask

   task automatic start_frame(input vec3 c);
      cam_in = c;
      start  = 1'b1;
      @(posedge clk); #1;
      start    = 1'b0;
      beat_cnt = 0;
   endtask

   task automatic wait_done(input int budget, output int n);
      bit found;
      n = 0;
      found = 1'b0;
      while (!found && n < budget) begin
         @(posedge clk); #1;
         n++;
         if (frame_done_out) found = 1'b1;
      end
      check("done_timeout", 96'(found), 96'(1));
   endtask

   task automatic wait_beat(input int hh, input int vv, input int budget);
      int n;
      n = 0;
      while (!(valid_out && int'(hcount_out) == hh && int'(vcount_out) == vv) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("beat_timeout", 96'(n < budget), 96'(1));
   endtask

   // Scoreboard: every handshake pops and compares one expected beat.
   always @(negedge clk) begin
      if (mon_en) begin
         if (frame_done_out) done_cnt++;
         if (valid_out && ready) begin
            beat_t got, exp;
            got.h   = hcount_out;
            got.v   = vcount_out;
            got.px  = hcount_fp_out;
            got.py  = vcount_fp_out;
            got.cam = cam_forward_out;
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL beat_unexpected got h=%0d v=%0d", got.h, got.v);
            end
            if (sb.size() != 0) begin
               exp = sb.pop_front();
               checks++;
               assert (got === exp) else begin
                  errors++;
                  $error("FAIL beat got h=%0d v=%0d px=%0h py=%0h cam=%0h exp h=%0d v=%0d px=%0h py=%0h cam=%0h",
                         got.h, got.v, got.px, got.py, got.cam, exp.h, exp.v, exp.px, exp.py, exp.cam);
               end
            end
            beat_cnt++;
         end
      end
   end

   initial begin
      int  n;
      vec3 cam_a, cam_b, cam_c, cam_d, cam_e, cam_f, cam_g, cam_h;
      cam_a = mkcam(1, 2, 3);
      cam_b = mkcam(4, 5, 6);
      cam_c = mkcam(-1, 0, 1);
      cam_d = mkcam(9, 9, 9);
      cam_e = mkcam(7, -7, 7);
      cam_f = mkcam(0, 0, -1);
      cam_g = mkcam(2, 3, 4);
      cam_h = mkcam(-5, 6, -7);

      // Reset state
      #2;
      check("rst_valid", 96'(valid_out), 96'(0));
      check("rst_busy", 96'(busy_out), 96'(0));
      check("rst_done", 96'(frame_done_out), 96'(0));
      check("rst_h", 96'(hcount_out), 96'(0));
      check("rst_v", 96'(vcount_out), 96'(0));
      check("rst_px", 96'(hcount_fp_out), 96'(0));
      check("rst_py", 96'(vcount_fp_out), 96'(0));
      check("rst_cam", cam_forward_out, 96'(0));
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Frame 1: free-flowing
      ready = 1'b1;
      push_frame(cam_a);
      start_frame(cam_a);
      check("load_valid", 96'(valid_out), 96'(0));
      check("load_busy", 96'(busy_out), 96'(1));
      check("load_cam", cam_forward_out, cam_a);
      @(posedge clk); #1;
      check("first_valid", 96'(valid_out), 96'(1));
      check("first_px", 96'(hcount_fp_out), 96'(fp'(-2 * ONE)));
      check("first_py", 96'(vcount_fp_out), 96'(fp'(-ONE)));
      wait_done(20, n);
      check("f1_cycles", 96'(n), 96'(8));
      check("f1_done_busy", 96'(busy_out), 96'(0));
      check("f1_done_valid", 96'(valid_out), 96'(0));
      check("f1_beats", 96'(beat_cnt), 96'(8));
      @(posedge clk); #1;
      check("f1_done_pulse", 96'(frame_done_out), 96'(0));
      check("f1_done_cnt", 96'(done_cnt), 96'(1));

      // Frame 2: backpressure at beat 3 plus an ignored mid-frame start
      push_frame(cam_b);
      start_frame(cam_b);
      wait_beat(2, 0, 10);
      ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", 96'(valid_out), 96'(1));
         check("bp_h", 96'(hcount_out), 96'(2));
         check("bp_v", 96'(vcount_out), 96'(0));
         check("bp_px", 96'(hcount_fp_out), 96'(fp'(0)));
         check("bp_py", 96'(vcount_fp_out), 96'(fp'(-ONE)));
         if (i == 1) begin
            cam_in = cam_d;
            start  = 1'b1;
         end
         if (i == 2) begin
            start = 1'b0;
            check("mid_start_busy", 96'(busy_out), 96'(1));
            check("mid_start_cam", cam_forward_out, cam_b);
         end
      end
      ready = 1'b1;
      wait_done(20, n);
      check("f2_beats", 96'(beat_cnt), 96'(8));
      check("f2_sb_empty", 96'(sb.size()), 96'(0));
      @(posedge clk); #1;

      // Frame 3: ready toggling every cycle
      push_frame(cam_c);
      start_frame(cam_c);
      @(posedge clk); #1;
      n = 0;
      while (!frame_done_out && n < 40) begin
         @(posedge clk); #1;
         n++;
         ready = ~ready;
      end
      ready = 1'b1;
      check("tog_cycles", 96'(n), 96'(15));
      check("tog_beats", 96'(beat_cnt), 96'(8));
      check("tog_sb_empty", 96'(sb.size()), 96'(0));
      @(posedge clk); #1;

      // Frame 4: reset at beat 5, then a full fresh frame
      push_frame(cam_e);
      start_frame(cam_e);
      wait_beat(0, 1, 20);
      rst_n = 1'b0;
      #1;
      check("abort_valid", 96'(valid_out), 96'(0));
      check("abort_busy", 96'(busy_out), 96'(0));
      check("abort_h", 96'(hcount_out), 96'(0));
      check("abort_v", 96'(vcount_out), 96'(0));
      check("abort_beats", 96'(beat_cnt), 96'(4));
      @(posedge clk); #1;
      sb.delete();
      rst_n = 1'b1;
      check("abort_no_done", 96'(frame_done_out), 96'(0));
      check("abort_done_cnt", 96'(done_cnt), 96'(3));
      @(posedge clk); #1;
      push_frame(cam_f);
      start_frame(cam_f);
      wait_done(20, n);
      check("post_rst_cycles", 96'(n), 96'(9));
      check("post_rst_beats", 96'(beat_cnt), 96'(8));
      @(posedge clk); #1;

      // Back-to-back frames
      push_frame(cam_g);
      start_frame(cam_g);
      wait_done(20, n);
      check("b2b1_beats", 96'(beat_cnt), 96'(8));
      @(posedge clk); #1;
      push_frame(cam_h);
      start_frame(cam_h);
      check("b2b2_busy", 96'(busy_out), 96'(1));
      check("b2b2_cam", cam_forward_out, cam_h);
      wait_done(20, n);
      check("b2b2_cycles", 96'(n), 96'(9));
      check("b2b2_beats", 96'(beat_cnt), 96'(8));
      @(posedge clk); #1;
      check("final_done_cnt", 96'(done_cnt), 96'(6));
      check("final_sb_empty", 96'(sb.size()), 96'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
